// File: rtl/diffusion_pkg.sv
// Shared definitions for the AES diffusion stages (forward and reverse).
// Holds the state/column widths, the engine FSM state encoding and the
// GF(2^8) helpers used by the column mixers.
package diffusion_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = STATE_W / COL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by x in GF(2^8), reducing by the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational AES MixColumns for a single 32-bit column.
// Ports:
//   col_i  column in,  row r in bits [8r+7:8r]
//   col_o  column out, same byte mapping
module mix_column
  import diffusion_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_i[7:0];
  assign a1 = col_i[15:8];
  assign a2 = col_i[23:16];
  assign a3 = col_i[31:24];

  assign b0 = xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
  assign b1 = a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3;
  assign b2 = a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3);
  assign b3 = gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3);

  assign col_o = {b3, b2, b1, b0};

endmodule

// File: rtl/forward_diffusion.sv
// Sequential forward-diffusion (AES MixColumns) engine.
// Accepts one 128-bit state over valid/ready, diffuses COLS_PER_CYCLE
// columns per clock and holds the result until the consumer takes it.
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   engine can take in_data this cycle
//   in_data    input state, byte[r][c] = bits [32c+8r+7 : 32c+8r]
//   out_valid  out_data holds a completed diffused state
//   out_ready  consumer accepts out_data
//   out_data   diffused state, same byte mapping as in_data
//   busy       engine is diffusing
module forward_diffusion
  import diffusion_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $fatal(1, "forward_diffusion: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // cnt wraps in 2 bits, so a step of 4 is a step of 0: one pass, done.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_e             state_q;
  logic [1:0]         cnt_q;
  logic [STATE_W-1:0] work_q;
  logic [STATE_W-1:0] out_data_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               accept;

  logic [1:0]       col_sel  [COLS_PER_CYCLE];
  logic [6:0]       col_base [COLS_PER_CYCLE];
  logic [COL_W-1:0] mix_in   [COLS_PER_CYCLE];
  logic [COL_W-1:0] mix_out  [COLS_PER_CYCLE];

  // Ready in DONE follows out_ready so a new state can enter on the same
  // edge as the output handshake; it never looks at in_valid.
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign col_sel[g]  = cnt_q + 2'(g);
    assign col_base[g] = {col_sel[g], 5'd0};
    assign mix_in[g]   = work_q[col_base[g] +: COL_W];

    mix_column u_mix_column (
      .col_i (mix_in[g]),
      .col_o (mix_out[g])
    );
  end

  // NOTE: the work register is pure datapath, only meaningful after an
  // accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      work_q <= in_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= BUSY;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            out_data_q[col_base[g] +: COL_W] <= mix_out[g];
          end
          cnt_q <= cnt_q + CNT_STEP;
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q <= BUSY;
              cnt_q   <= 2'd0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_forward_diffusion.sv
// Directed bench for forward_diffusion: three instances (1, 2 and 4
// columns per cycle) share the input side; most checks target the
// single-column instance, the wider ones are checked for latency, value
// and round trip through an inverse MixColumns model.
module tb_forward_diffusion;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;

  logic         in_ready1, out_valid1, busy1;
  logic         in_ready2, out_valid2, busy2;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] out_data1, out_data2, out_data4;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  forward_diffusion #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .busy(busy1)
  );

  forward_diffusion #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .busy(busy2)
  );

  forward_diffusion #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] col(input logic [7:0] r0, input logic [7:0] r1,
                                      input logic [7:0] r2, input logic [7:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse MixColumns, standing in for the reverse-diffusion stage.
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      r[32*c +: 8]    = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[32*c+8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid1(output int lat);
    int k;
    k = 0;
    while (!out_valid1 && k < 20) begin
      step();
      k++;
    end
    lat = out_valid1 ? k : -1;
  endtask

  localparam logic [31:0] ONES = 32'h01010101;

  logic [127:0] in_a, in_b, in_c, in_f;
  logic [127:0] exp_a, exp_b, exp_c, exp_f;
  logic [127:0] vin  [3];
  logic [127:0] vexp [3];

  task automatic send_single(input string tag, input logic [127:0] d, input logic [127:0] e);
    int lat;
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    check({tag, "_busy"}, 128'(busy1), 128'(1));
    wait_valid1(lat);
    check({tag, "_lat"}, 128'(lat), 128'(4));
    check({tag, "_data"}, out_data1, e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_released"}, 128'(out_valid1), 128'(0));
  endtask

  initial begin
    int lat, lat1, lat2, lat4, last_hs, idx_in, idx_out, seen;
    logic acc, hs;
    logic [127:0] od;

    in_a  = {ONES, ONES, ONES, col(8'hdb, 8'h13, 8'h53, 8'h45)};
    exp_a = {ONES, ONES, ONES, col(8'h8e, 8'h4d, 8'ha1, 8'hbc)};
    in_b  = {ONES, col(8'hf2, 8'h0a, 8'h22, 8'h5c), ONES, ONES};
    exp_b = {ONES, col(8'h9f, 8'hdc, 8'h58, 8'h9d), ONES, ONES};
    in_c  = {col(8'hc6, 8'hc6, 8'hc6, 8'hc6), ONES, ONES, ONES};
    exp_c = in_c;
    in_f  = {col(8'hc6, 8'hc6, 8'hc6, 8'hc6), ONES,
             col(8'h2d, 8'h26, 8'h31, 8'h4c), col(8'hd4, 8'hd4, 8'hd4, 8'hd5)};
    exp_f = {col(8'hc6, 8'hc6, 8'hc6, 8'hc6), ONES,
             col(8'h4d, 8'h7e, 8'hbd, 8'hf8), col(8'hd5, 8'hd5, 8'hd7, 8'hd6)};

    // Reset
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    step();
    step();
    check("rst_out_valid", 128'(out_valid1), 128'(0));
    check("rst_out_data", out_data1, 128'h0);
    check("rst_busy", 128'(busy1), 128'(0));
    reset = 1'b0;
    step();
    check("post_rst_in_ready", 128'(in_ready1), 128'(1));

    // Single-column vectors and the full state
    send_single("col_db", in_a, exp_a);
    send_single("col_f2", in_b, exp_b);
    send_single("col_c6", in_c, exp_c);
    send_single("full", in_f, exp_f);

    // Backpressure
    in_valid = 1'b1;
    in_data  = in_f;
    step();
    in_valid = 1'b0;
    wait_valid1(lat);
    check("bp_lat", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_data", out_data1, exp_f);
      check("bp_in_ready_low", 128'(in_ready1), 128'(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = in_a;
    #1;
    check("bp_in_ready_up", 128'(in_ready1), 128'(1));
    step();
    check("bp_hs_valid_drop", 128'(out_valid1), 128'(0));
    check("bp_new_accept", 128'(busy1), 128'(1));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_valid1(lat);
    check("bp_next_lat", 128'(lat), 128'(4));
    check("bp_next_data", out_data1, exp_a);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Back-to-back with out_ready held high
    vin[0] = in_b;  vexp[0] = exp_b;
    vin[1] = in_c;  vexp[1] = exp_c;
    vin[2] = in_f;  vexp[2] = exp_f;
    idx_in    = 0;
    idx_out   = 0;
    last_hs   = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && idx_out < 3; cyc++) begin
      in_valid = (idx_in < 3);
      in_data  = (idx_in < 3) ? vin[idx_in] : 128'h0;
      #1;
      acc = in_valid && in_ready1;
      hs  = out_valid1 && out_ready;
      od  = out_data1;
      step();
      if (hs) begin
        check("b2b_data", od, vexp[idx_out]);
        if (idx_out > 0) check("b2b_gap", 128'(cyc - last_hs), 128'(5));
        last_hs = cyc;
        idx_out++;
      end
      if (acc) idx_in++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", 128'(idx_out), 128'(3));

    // Reset in the middle of BUSY
    step();
    in_valid = 1'b1;
    in_data  = in_b;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_out_valid", 128'(out_valid1), 128'(0));
    check("midrst_out_data", out_data1, 128'h0);
    check("midrst_in_ready", 128'(in_ready1), 128'(1));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid1) seen = 1;
    end
    check("midrst_no_output", 128'(seen), 128'(0));
    check("midrst_data_still_zero", out_data1, 128'h0);

    // Wider datapaths: latency, value and round trip
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = in_f;
    step();
    in_valid = 1'b0;
    lat1 = -1;
    lat2 = -1;
    lat4 = -1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (lat1 < 0 && out_valid1) lat1 = k;
      if (lat2 < 0 && out_valid2) lat2 = k;
      if (lat4 < 0 && out_valid4) lat4 = k;
    end
    check("w1_lat", 128'(lat1), 128'(4));
    check("w2_lat", 128'(lat2), 128'(2));
    check("w4_lat", 128'(lat4), 128'(1));
    check("w2_data", out_data2, exp_f);
    check("w4_data", out_data4, exp_f);
    check("w1_roundtrip", inv_mix(out_data1), in_f);
    check("w2_roundtrip", inv_mix(out_data2), in_f);
    check("w4_roundtrip", inv_mix(out_data4), in_f);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/forward_diffusion.md
# forward_diffusion

Sequential forward-diffusion (AES MixColumns) engine for the encrypt datapath. It accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It holds the diffused state in an output register until the downstream stage accepts it. It is the encrypt-side counterpart of the existing reverse-diffusion stage, and its output must round-trip through that stage to the original input.

## Interface
- COLS_PER_CYCLE, 1: columns processed per clock; legal values 1, 2, 4. Any other value is an elaboration error.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  128  state; byte[row r][col c] = bits [32c+8r+7 : 32c+8r].
- out_valid  output  1  out_data holds a completed diffused state.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  diffused state, same byte mapping as in_data.
- busy  output  1  high in BUSY state.

## Operation
- Per column (a0..a3 = rows 0..3):
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- GF(2^8) arithmetic:
  - xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0).
  - 3·x = xtime(x) ^ x.
  - All results are 8 bits; no carries.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the work register, clear the column counter, go to BUSY.
  - BUSY: each edge, write columns [cnt .. cnt+COLS_PER_CYCLE-1] of the work register, diffused, into out_data. cnt advances by COLS_PER_CYCLE (2-bit wrap). When the last group is written, go to DONE and set out_valid.
  - DONE: out_valid=1 and out_data held stable. On out_ready, clear out_valid. If in_valid is also high, capture the new input and go to BUSY; otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and never depends on in_valid.
- in_data is ignored outside an accepting cycle. Input changes during BUSY have no effect.
- out_data columns not yet written in BUSY keep their previous value. Only the final value is guaranteed, during DONE.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=128'h0, busy=0, cnt=0. in_ready reads 1 in the cycle after reset deasserts. While reset is high, the outputs are at their reset values from the first edge onward.
- Latency: accept edge T → out_valid high after edge T + 4/COLS_PER_CYCLE (4, 2 or 1 cycles).
- Throughput with out_ready held high: one state every 4/COLS_PER_CYCLE + 1 cycles. The next state is accepted on the same edge as the output handshake.
- Backpressure: out_valid/out_data are held indefinitely while out_ready=0. No new input is accepted in that period.
- Reset mid-operation (BUSY or DONE): the in-flight state is discarded with no output handshake, and all reset values apply at the next edge.
- Simultaneous out handshake and input accept in DONE: both take effect on the same edge. out_valid drops for at least 4/COLS_PER_CYCLE cycles.

## Structure
- Package diffusion_pkg holds:
  - STATE_W=128, COL_W=32
  - the FSM state enum {IDLE, BUSY, DONE}
  - the functions xtime and gf_mul3
- Sub-module mix_column is combinational, 32-bit column in to 32-bit column out. It is instantiated COLS_PER_CYCLE times, and column selection is muxed by cnt.
- The reverse stage reuses xtime from diffusion_pkg.

## Test plan
- Single column vectors, COLS_PER_CYCLE=1; all other columns 01010101, whose result is 01010101:
  - column db,13,53,45 (rows 0..3) → 8e,4d,a1,bc
  - column f2,0a,22,5c → 9f,dc,58,9d
  - column c6 ×4 → c6 ×4
- Full state with columns d4d4d4d5, 2d26314c, 01010101, c6c6c6c6 (row0 first):
  - expect columns d5d5d7d6, 4d7ebdf8, 01010101, c6c6c6c6
  - out_valid exactly 4 cycles after the accept edge
- Backpressure: hold out_ready=0 for 10 cycles.
  - out_data stable and in_ready=0 throughout.
  - Then raise out_ready together with in_valid: the handshake and the new accept happen on the same edge.
- Back-to-back with out_ready=1: three states give one output every 5 cycles, in order, with correct values.
- Reset asserted mid-BUSY (cycle 2):
  - next edge: out_valid=0, out_data=0, in_ready=1
  - the discarded state never appears on the output
- COLS_PER_CYCLE=4 and =2: same vectors, latency 1 and 2 cycles. Feeding the output into the reverse-diffusion stage returns the original input.
